// File: rtl/mem_arbiter_if.sv
// Strobe/done word-memory bus shared by the requesters and the memory port.
// The master drives the request fields and strobes; the slave answers with
// a one-cycle done pulse and read data.
interface mem_arbiter_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        wstrobe;
    logic        rstrobe;
    logic [31:0] rdata;
    logic        done;

    modport master (
        output addr, wdata, wmask, wstrobe, rstrobe,
        input  rdata, done
    );

    modport slave (
        input  addr, wdata, wmask, wstrobe, rstrobe,
        output rdata, done
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port word memory.
// Requests are captured per requester, issued one at a time, and the memory
// completion (or a timeout error) is routed back to the owner.
module mem_arbiter #(
    parameter int unsigned TIMEOUT  = 0,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  s0,
    mem_arbiter_if.slave  s1,
    mem_arbiter_if.master mem,
    output logic          grant,
    output logic          busy,
    output logic          timeout_err
);

    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e          state;
    logic            owner;
    logic            last_grant;
    logic [CntW-1:0] wait_cnt;

    // Per-requester capture registers
    logic [1:0]  pend;
    logic [1:0]  cap_write;
    logic [31:0] cap_addr  [2];
    logic [31:0] cap_wdata [2];
    logic [3:0]  cap_wmask [2];

    // Incoming request view, indexed by requester
    logic [1:0]  req_w;
    logic [1:0]  req_r;
    logic [1:0]  strb;
    logic [31:0] in_addr  [2];
    logic [31:0] in_wdata [2];
    logic [3:0]  in_wmask [2];

    assign req_w       = {s1.wstrobe, s0.wstrobe};
    assign req_r       = {s1.rstrobe, s0.rstrobe};
    assign strb        = req_w | req_r;
    assign in_addr[0]  = s0.addr;
    assign in_addr[1]  = s1.addr;
    assign in_wdata[0] = s0.wdata;
    assign in_wdata[1] = s1.wdata;
    assign in_wmask[0] = s0.wmask;
    assign in_wmask[1] = s1.wmask;

    logic mem_ok;
    logic to_fire;
    logic finish;

    assign mem_ok  = (state == StWait) && mem.done;
    assign to_fire = (TIMEOUT != 0) && (state == StWait) && !mem.done &&
                     (wait_cnt == CntW'(TIMEOUT));
    assign finish  = mem_ok || to_fire;

    // Pending view including strobes accepted this cycle, so an idle arbiter
    // can issue in the cycle right after the strobe.
    logic [1:0]  completing;
    logic [1:0]  accept;
    logic [1:0]  eff_pend;
    logic [1:0]  eff_write;
    logic [31:0] eff_addr  [2];
    logic [31:0] eff_wdata [2];
    logic [3:0]  eff_wmask [2];

    // Accept strobes unless the requester already has an unfinished request
    always_comb begin
        completing = '0;
        accept     = '0;
        eff_pend   = '0;
        eff_write  = '0;
        for (int i = 0; i < 2; i++) begin
            completing[i] = finish && (owner == 1'(i));
            accept[i]     = strb[i] && (!pend[i] || completing[i]);
            eff_pend[i]   = (pend[i] && !completing[i]) || accept[i];
            eff_write[i]  = accept[i] ? req_w[i] : cap_write[i];
            eff_addr[i]   = accept[i] ? in_addr[i] : cap_addr[i];
            eff_wdata[i]  = accept[i] ? in_wdata[i] : cap_wdata[i];
            eff_wmask[i]  = accept[i] ? in_wmask[i] : cap_wmask[i];
        end
    end

    logic next_owner;
    logic launch;

    // From WAIT only the other requester can follow; from IDLE a tie goes
    // to the requester that was not served last.
    assign next_owner = (state == StWait) ? ~owner :
                        (eff_pend == 2'b11) ? ~last_grant : eff_pend[1];
    assign launch     = ((state == StIdle) && (|eff_pend)) ||
                        ((state == StWait) && finish && eff_pend[~owner]);

    // Capture strobed requests and track which are still outstanding
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend      <= '0;
            cap_write <= '0;
            for (int i = 0; i < 2; i++) begin
                cap_addr[i]  <= '0;
                cap_wdata[i] <= '0;
                cap_wmask[i] <= '0;
            end
        end else begin
            pend <= eff_pend;
            for (int i = 0; i < 2; i++) begin
                if (accept[i]) begin
                    cap_write[i] <= req_w[i];
                    cap_addr[i]  <= in_addr[i];
                    cap_wdata[i] <= in_wdata[i];
                    cap_wmask[i] <= in_wmask[i];
                end
            end
        end
    end

    // Arbitration FSM with registered memory-side outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= StIdle;
            owner       <= 1'b0;
            last_grant  <= 1'b1;
            wait_cnt    <= '0;
            mem.addr    <= '0;
            mem.wdata   <= '0;
            mem.wmask   <= '0;
            mem.wstrobe <= 1'b0;
            mem.rstrobe <= 1'b0;
        end else begin
            mem.wstrobe <= 1'b0;
            mem.rstrobe <= 1'b0;
            case (state)
                StIdle: ;
                StIssue: begin
                    wait_cnt <= '0;
                    state    <= StWait;
                end
                StWait: begin
                    if (finish) begin
                        last_grant <= owner;
                        state      <= StIdle;
                    end else if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
            // A launch overrides the state chosen above
            if (launch) begin
                state       <= StIssue;
                owner       <= next_owner;
                mem.addr    <= eff_addr[next_owner];
                mem.wdata   <= eff_wdata[next_owner];
                mem.wmask   <= eff_wmask[next_owner];
                mem.wstrobe <= eff_write[next_owner];
                mem.rstrobe <= !eff_write[next_owner];
            end
        end
    end

    logic        done0;
    logic        done1;
    logic [31:0] done_data;

    assign done0       = finish && !owner;
    assign done1       = finish && owner;
    assign done_data   = mem_ok ? mem.rdata : ERR_DATA;
    assign s0.done     = done0;
    assign s1.done     = done1;
    assign s0.rdata    = done0 ? done_data : '0;
    assign s1.rdata    = done1 ? done_data : '0;
    assign grant       = owner;
    assign busy        = (state != StIdle);
    assign timeout_err = to_fire;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter with a transaction-level
// reference model (outstanding requests, round-robin pick, reference memory).
module tb_mem_arbiter;
    localparam int unsigned TO  = 4;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic grant, busy, timeout_err;

    mem_arbiter_if s0_bus ();
    mem_arbiter_if s1_bus ();
    mem_arbiter_if mem_bus ();

    mem_arbiter #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
        .clk(clk), .rst(rst), .s0(s0_bus), .s1(s1_bus), .mem(mem_bus),
        .grant(grant), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cycle = 0;

    // Reference model state
    logic [31:0] ref_mem [64];
    bit          out_v [2];
    bit          out_w [2];
    logic [31:0] out_a [2];
    logic [31:0] out_d [2];
    logic [3:0]  out_m [2];
    int          out_c [2];
    bit          act;
    int          act_own;
    int          act_c;
    bit          last;
    int          exp_grant;
    int          done_who [$];
    logic [31:0] done_data [$];
    int          done_grant [$];
    bit          rr_mode = 0;
    int          rr_left = 0;
    bit          rand_mode = 0;

    // Memory environment
    logic [31:0] env_mem [64];
    int          m_cnt = 0;
    bit          m_w;
    logic [31:0] m_a, m_d;
    logic [3:0]  m_m;
    bit          mem_en = 1;
    int          mem_delay = 1;
    bit          rand_delay = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic request(input int i, input bit w, input bit both, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] m);
        if (i == 0) begin
            s0_bus.wstrobe = w; s0_bus.rstrobe = !w || both;
            s0_bus.addr = a; s0_bus.wdata = d; s0_bus.wmask = m;
        end else begin
            s1_bus.wstrobe = w; s1_bus.rstrobe = !w || both;
            s1_bus.addr = a; s1_bus.wdata = d; s1_bus.wmask = m;
        end
        out_v[i] = 1; out_w[i] = w; out_a[i] = a; out_d[i] = d; out_m[i] = m;
        out_c[i] = cycle;
    endtask

    task automatic rand_req(input int i);
        bit w;
        w = 1'($urandom_range(0, 1));
        request(i, w, w && ($urandom_range(0, 3) == 0), 32'h80 + ($urandom_range(0, 31) << 2),
                $urandom, 4'($urandom_range(0, 15)));
    endtask

    task automatic model_reset();
        out_v[0] = 0; out_v[1] = 0; act = 0; last = 1; exp_grant = 0;
    endtask

    // Advance to the next cycle: clear one-cycle strobes and run the memory
    task automatic step();
        @(posedge clk);
        #1;
        cycle++;
        s0_bus.wstrobe = 0; s0_bus.rstrobe = 0;
        s1_bus.wstrobe = 0; s1_bus.rstrobe = 0;
        mem_bus.done = 0; mem_bus.rdata = '0;
        if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0 && mem_en) begin
                mem_bus.done = 1;
                if (m_w) env_mem[m_a[7:2]] = merge(env_mem[m_a[7:2]], m_d, m_m);
                else mem_bus.rdata = env_mem[m_a[7:2]];
            end
        end
        if (mem_bus.rstrobe || mem_bus.wstrobe) begin
            chk("mem_overlap", 32'(m_cnt), 0);
            m_cnt = rand_delay ? int'($urandom_range(1, 4)) : mem_delay;
            m_w = mem_bus.wstrobe; m_a = mem_bus.addr; m_d = mem_bus.wdata; m_m = mem_bus.wmask;
        end
    endtask

    // Mid-cycle observation against the reference model
    task automatic mon();
        bit issue, exp_done, exp_to, e0, e1;
        logic d [2];
        logic [31:0] rd [2];
        logic [31:0] expd;
        int own;
        @(negedge clk);
        d[0] = s0_bus.done; d[1] = s1_bus.done;
        rd[0] = s0_bus.rdata; rd[1] = s1_bus.rdata;
        issue = mem_bus.rstrobe || mem_bus.wstrobe;
        chk("busy", busy, act || issue);
        exp_done = act && cycle > act_c && (mem_bus.done || (cycle - act_c == int'(TO) + 1));
        exp_to = exp_done && !mem_bus.done;
        for (int i = 0; i < 2; i++) begin
            chk(i == 0 ? "s0_done" : "s1_done", d[i], exp_done && act_own == i);
            if (!d[i]) chk(i == 0 ? "s0_rdata_idle" : "s1_rdata_idle", rd[i], 0);
            if (d[i]) begin
                done_who.push_back(i); done_data.push_back(rd[i]); done_grant.push_back(grant);
            end
        end
        chk("timeout_err", timeout_err, exp_to);
        if (exp_done) begin
            own = act_own;
            expd = exp_to ? ERR : (out_w[own] ? 32'h0 : ref_mem[out_a[own][7:2]]);
            chk("done_rdata", rd[own], expd);
            if (!exp_to && out_w[own])
                ref_mem[out_a[own][7:2]] = merge(ref_mem[out_a[own][7:2]], out_d[own], out_m[own]);
            last = own[0]; out_v[own] = 0; act = 0;
            if (rr_mode && rr_left > 0) begin
                rand_req(own); rr_left--;
            end else if (rand_mode && $urandom_range(0, 4) < 2) begin
                rand_req(own);
            end
        end
        if (issue) begin
            chk("issue_while_active", act, 0);
            chk("one_strobe", mem_bus.rstrobe && mem_bus.wstrobe, 0);
            e0 = out_v[0] && out_c[0] < cycle;
            e1 = out_v[1] && out_c[1] < cycle;
            chk("issue_has_candidate", e0 || e1, 1);
            if (e0 || e1) begin
                own = (e0 && e1) ? int'(!last) : (e1 ? 1 : 0);
                chk("issue_addr", mem_bus.addr, out_a[own]);
                chk("issue_kind", mem_bus.wstrobe, out_w[own]);
                if (out_w[own]) begin
                    chk("issue_wdata", mem_bus.wdata, out_d[own]);
                    chk("issue_wmask", 32'(mem_bus.wmask), 32'(out_m[own]));
                end
                act = 1; act_own = own; act_c = cycle; exp_grant = own;
            end
        end
        chk("grant", grant, exp_grant[0]);
    endtask

    task automatic chk_reset_vals();
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_s0", {s0_bus.done, s0_bus.rdata}, 0);
        chk("rst_s1", {s1_bus.done, s1_bus.rdata}, 0);
        chk("rst_mem_addr", mem_bus.addr, 0);
        chk("rst_mem_wdata", mem_bus.wdata, 0);
        chk("rst_mem_ctl", {mem_bus.wmask, mem_bus.wstrobe, mem_bus.rstrobe}, 0);
    endtask

    task automatic reset_dut();
        rst = 0;
        model_reset();
        repeat (2) begin
            mon(); chk_reset_vals(); step();
        end
        rst = 1;
    endtask

    task automatic run_until_dones(input int n, input int budget, input string tag);
        for (int k = 0; k < budget && done_who.size() < n; k++) begin
            mon(); step();
        end
        chk(tag, 32'(done_who.size()), 32'(n));
    endtask

    task automatic clear_log();
        done_who.delete(); done_data.delete(); done_grant.delete();
    endtask

    initial begin
        int sc;
        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = '0; env_mem[i] = '0;
        end
        ref_mem[16] = 32'h12345678; env_mem[16] = 32'h12345678;
        s0_bus.addr = '0; s0_bus.wdata = '0; s0_bus.wmask = '0;
        s0_bus.wstrobe = 0; s0_bus.rstrobe = 0;
        s1_bus.addr = '0; s1_bus.wdata = '0; s1_bus.wmask = '0;
        s1_bus.wstrobe = 0; s1_bus.rstrobe = 0;
        mem_bus.done = 0; mem_bus.rdata = '0;
        model_reset();
        reset_dut();
        repeat (3) begin mon(); step(); end

        // Single read: strobe in c, memory strobe in c+1, done in c+2
        request(0, 0, 0, 32'h40, 0, 0);
        mon(); chk("rd_busy_c", busy, 0); step();
        mon();
        chk("rd_mem_rstrobe", mem_bus.rstrobe, 1);
        chk("rd_mem_wstrobe", mem_bus.wstrobe, 0);
        chk("rd_mem_addr", mem_bus.addr, 32'h40);
        step();
        mon();
        chk("rd_s0_done", s0_bus.done, 1);
        chk("rd_s0_rdata", s0_bus.rdata, 32'h12345678);
        chk("rd_s1_done", s1_bus.done, 0);
        step();
        mon(); chk("rd_idle_after", busy, 0); step();

        // Collision right after reset: s0 write wins, s1 reads merged word
        reset_dut();
        clear_log();
        request(0, 1, 0, 32'h10, 32'hA5A5A5A5, 4'b0011);
        request(1, 0, 0, 32'h10, 0, 0);
        run_until_dones(2, 30, "col_count");
        if (done_who.size() >= 2) begin
            chk("col_first", 32'(done_who[0]), 0);
            chk("col_second", 32'(done_who[1]), 1);
            chk("col_s1_rdata", done_data[1], 32'h0000A5A5);
            chk("col_grant0", 32'(done_grant[0]), 0);
            chk("col_grant1", 32'(done_grant[1]), 1);
        end

        // Round-robin: re-strobe on every done, 8 transactions in total
        clear_log();
        rr_mode = 1; rr_left = 6;
        rand_req(0); rand_req(1);
        run_until_dones(8, 200, "rr_count");
        rr_mode = 0;
        for (int k = 0; k < done_who.size(); k++) chk("rr_order", 32'(done_who[k]), 32'(k % 2));

        // Timeout: memory never answers
        repeat (2) begin mon(); step(); end
        mem_en = 0;
        request(1, 0, 0, 32'h40, 0, 0);
        sc = cycle;
        for (int k = 0; k < 9; k++) begin
            mon();
            if (cycle == sc + 6) begin
                chk("to_s1_done", s1_bus.done, 1);
                chk("to_s1_rdata", s1_bus.rdata, ERR);
                chk("to_err", timeout_err, 1);
            end else begin
                chk("to_err_quiet", timeout_err, 0);
                chk("to_s1_quiet", s1_bus.done, 0);
            end
            if (cycle == sc + 7) chk("to_idle", busy, 0);
            step();
        end
        mem_en = 1;

        // Reset while s0 waits; the late memory done must be dropped
        mem_delay = 3;
        request(0, 0, 0, 32'h40, 0, 0);
        mon(); step();
        mon(); step();
        reset_dut();
        mon();
        chk("rst_late_done_seen", mem_bus.done, 1);
        chk("rst_no_s0_done", s0_bus.done, 0);
        step();
        mem_delay = 1;
        repeat (2) begin mon(); step(); end
        clear_log();
        request(0, 0, 0, 32'h40, 0, 0);
        run_until_dones(1, 20, "rst_fresh_count");
        if (done_who.size() >= 1) chk("rst_fresh_rdata", done_data[0], 32'h12345678);

        // Both strobes high is a write
        request(1, 1, 1, 32'h20, 32'h11223344, 4'hF);
        mon(); step();
        mon();
        chk("both_wstrobe", mem_bus.wstrobe, 1);
        chk("both_rstrobe", mem_bus.rstrobe, 0);
        step();
        repeat (3) begin mon(); step(); end
        clear_log();
        request(0, 0, 0, 32'h20, 0, 0);
        run_until_dones(1, 20, "both_rb_count");
        if (done_who.size() >= 1) chk("both_readback", done_data[0], 32'h11223344);

        // Randomized traffic with random memory latency
        rand_mode = 1; rand_delay = 1;
        for (int k = 0; k < 400; k++) begin
            mon(); step();
            for (int i = 0; i < 2; i++)
                if (!out_v[i] && $urandom_range(0, 2) == 0) rand_req(i);
        end
        rand_mode = 0;
        for (int k = 0; k < 100 && (out_v[0] || out_v[1] || act); k++) begin
            mon(); step();
        end
        chk("drain", {30'd0, out_v[0] || out_v[1], act}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter for the shared single-port word memory. It sits between the `cpu` core (requester 0) and a second bus master such as a loader or DMA (requester 1) on one side, and the `memory` instance on the other. Each side uses the codebase strobe/done memory protocol. The block captures strobed requests, grants them round-robin, issues one transaction at a time to memory, and routes `mem_done`/`mem_rdata` back to the owner. An optional timeout converts a hung access into an error completion.

## Interface
- `TIMEOUT`, default 0: cycles to wait in WAIT for `mem_done` before forcing completion; 0 disables the timeout.
- `ERR_DATA`, default 32'hDEADBEEF: read data returned to the owner on a timeout.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `sN_addr`  in  32  request byte address (N = 0, 1).
- `sN_wdata`  in  32  write data.
- `sN_wmask`  in  4  byte write enables.
- `sN_wstrobe`  in  1  one-cycle write request.
- `sN_rstrobe`  in  1  one-cycle read request.
- `sN_rdata`  out  32  read data, valid when `sN_done` is high.
- `sN_done`  out  1  one-cycle completion to requester N.
- `mem_addr`, `mem_wdata`  out  32  registered, from the captured request.
- `mem_wmask`  out  4  registered.
- `mem_wstrobe`, `mem_rstrobe`  out  1  one-cycle strobes to memory.
- `mem_rdata`  in  32  memory read data.
- `mem_done`  in  1  memory completion pulse.
- `grant`  out  1  index of the current or most recent owner.
- `busy`  out  1  high in ISSUE and WAIT.
- `timeout_err`  out  1  one-cycle pulse when a timeout fires.

## Operation
- Per-requester capture register: `pendN`, addr, wdata, wmask, and `is_write`.
  - A strobe sets `pendN` and latches the request fields.
  - If `wstrobe` and `rstrobe` are both high, the request is a write.
  - A strobe while `pendN` is already set and not completing this cycle is ignored. This is a protocol violation and is not flagged.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE -> ISSUE when any `pend` is set. Owner = the only pending requester. If both are pending, owner = the requester not equal to `last_grant`.
  - ISSUE lasts one cycle. It drives exactly one of `mem_rstrobe`/`mem_wstrobe` high with the owner's captured fields, then goes to WAIT.
  - WAIT, on `mem_done`: `s<owner>_done`=1 and `s<owner>_rdata`=`mem_rdata`, both combinational in the same cycle. `pend<owner>` is cleared and `last_grant` = owner. Next state is ISSUE if the other requester is pending, otherwise IDLE. A same-cycle strobe from the owner re-arms its `pend` and is served after the other requester if that one is pending.
  - WAIT, on timeout (`TIMEOUT`>0 and wait counter == `TIMEOUT` with no `mem_done`): owner done is pulsed with `ERR_DATA`, `timeout_err` pulses, and the transition is the same as a normal completion.
- `sN_rdata` is 0 whenever `sN_done` is low.
- `mem_done` seen in IDLE or ISSUE is ignored.
- A late `mem_done` after a timeout that lands in the next WAIT is accepted as that transaction's completion. This is a documented limitation.
- Wait counter: width clog2(TIMEOUT+1). It is cleared on entry to WAIT and increments each WAIT cycle. It saturates and does not wrap.

## Timing
- Reset values, asynchronous on `rst`=0:
  - state IDLE.
  - `pend0`=`pend1`=0.
  - `last_grant`=1, so requester 0 wins the first tie.
  - `grant`=0.
  - All `mem_*` outputs 0.
  - `sN_done`=0, `sN_rdata`=0, `busy`=0, `timeout_err`=0.
  - Counter 0.
- Reset mid-transaction abandons it:
  - No done is returned to the owner.
  - Both pendings are dropped.
  - A `mem_done` arriving after reset release is ignored.
- Latency: strobe in cycle c, with the arbiter idle.
  - `mem_*strobe` in cycle c+1.
  - With a memory that answers next cycle, `mem_done` and `sN_done` in c+2.
- Back-to-back service:
  - The second requester's ISSUE falls in the cycle after the first's done.
  - Memory sees at most one outstanding strobe.
- Fairness: with both requesters continuously re-requesting, grants alternate 0,1,0,1.

## Test plan
- Single read: s0 `rstrobe` at cycle 5 with addr 0x40, memory holding 0x12345678 -> `mem_rstrobe`/`mem_addr`=0x40 at cycle 6; `s0_done`=1 and `s0_rdata`=0x12345678 on the `mem_done` cycle; `s1_done` stays 0.
- Collision: s0 write (addr 0x10, data 0xA5A5A5A5, mask 4'b0011) and s1 read (addr 0x10) strobe in the same cycle after reset -> s0 is issued first; s1 then reads 0x0000A5A5 over prior zero contents; `grant` goes 0 then 1.
- Round-robin: both requesters re-strobe on each of their done pulses for 8 transactions -> grants strictly alternate; no done is ever delivered to the non-owner.
- Timeout: TIMEOUT=4, memory model never asserts `mem_done` -> after 4 WAIT cycles, `s1_done`=1 with rdata 0xDEADBEEF and `timeout_err`=1 for exactly one cycle; state returns to IDLE.
- Reset mid-WAIT: `rst` low for 2 cycles while s0 is waiting, then memory asserts `mem_done` -> no `s0_done`; all outputs are at their reset values during reset; a fresh s0 read afterwards completes normally.
- Both strobes high: s1 with `wstrobe`=`rstrobe`=1 -> only `mem_wstrobe` is asserted.
